// File: rtl/i2c_target_regs.sv
// I2C target responder with a small register file.
// A master writes a register pointer, then data bytes that land at the pointer
// with auto-increment; reads stream bytes out from the pointer the same way.
// SDA/SCL are synchronized and edge-detected on clk; clk must run >= 20x SCL.
//
// Handshake/timing contract: the bus has no valid/ready; the master owns SCL.
// SDA is sampled on the cycle an SCL rising edge is seen, and sda_oe only
// changes on the cycle after an SCL falling edge is seen, so the line is never
// moved by this block while SCL is high. reg_wr_en is a one-cycle strobe with
// reg_wr_addr/reg_wr_data valid in the same cycle; there is no back-pressure.
module i2c_target_regs #(
    parameter logic [6:0] DEV_ADDR = 7'h42,
    parameter int         NUM_REGS = 16,
    parameter int         PTR_W    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             scl_in,
    input  logic             sda_in,
    output logic             sda_oe,
    output logic             scl_oe,
    input  logic [PTR_W-1:0] loc_rd_addr,
    output logic [7:0]       loc_rd_data,
    output logic             reg_wr_en,
    output logic [PTR_W-1:0] reg_wr_addr,
    output logic [7:0]       reg_wr_data,
    output logic             busy,
    output logic [3:0]       dbg_state_o
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_ADDR      = 4'd1,
        S_ADDR_ACK  = 4'd2,
        S_PTR       = 4'd3,
        S_PTR_ACK   = 4'd4,
        S_WR_DATA   = 4'd5,
        S_WR_ACK    = 4'd6,
        S_RD_DATA   = 4'd7,
        S_RD_ACK    = 4'd8,
        S_WAIT_STOP = 4'd9
    } state_t;

    // Synchronizer and history flops
    logic scl_s1_q, scl_s2_q, scl_h_q;
    logic sda_s1_q, sda_s2_q, sda_h_q;

    // Protocol state
    state_t           state_q;
    logic [2:0]       bitcnt_q;
    logic [7:0]       shreg_q;
    logic [PTR_W-1:0] ptr_q;
    logic             rw_q;
    logic             ack_drv_q;
    logic             mack_q;
    logic             fall_q;
    logic             sda_oe_q;
    logic             busy_q;
    logic             wr_en_q;
    logic [PTR_W-1:0] wr_addr_q;
    logic [7:0]       wr_data_q;
    logic [7:0]       regs_q [NUM_REGS];

    // Edge and bus-condition decode
    logic       scl_rise, scl_fall, scl_edge;
    logic       sda_rise, sda_fall;
    logic       start_det, stop_det;
    logic [7:0] rx_byte_d;
    logic [7:0] rd_byte_d;
    logic       addr_match;

    assign scl_rise  = scl_s2_q & ~scl_h_q;
    assign scl_fall  = ~scl_s2_q & scl_h_q;
    assign scl_edge  = scl_rise | scl_fall;
    assign sda_rise  = sda_s2_q & ~sda_h_q;
    assign sda_fall  = ~sda_s2_q & sda_h_q;
    // SCL must be steadily high; a simultaneous SCL edge makes it a data bit.
    assign start_det = sda_fall & scl_s2_q & ~scl_edge;
    assign stop_det  = sda_rise & scl_s2_q & ~scl_edge;

    assign rx_byte_d  = {shreg_q[6:0], sda_s2_q};
    assign rd_byte_d  = regs_q[ptr_q];
    assign addr_match = (rx_byte_d[7:1] == DEV_ADDR) && (rx_byte_d[7:1] != 7'h00);

    assign sda_oe      = sda_oe_q;
    assign scl_oe      = 1'b0;
    assign loc_rd_data = regs_q[loc_rd_addr];
    assign reg_wr_en   = wr_en_q;
    assign reg_wr_addr = wr_addr_q;
    assign reg_wr_data = wr_data_q;
    assign busy        = busy_q;
    assign dbg_state_o = state_q;

    // Two-flop synchronizers plus a history flop for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_s1_q <= 1'b1;
            scl_s2_q <= 1'b1;
            scl_h_q  <= 1'b1;
            sda_s1_q <= 1'b1;
            sda_s2_q <= 1'b1;
            sda_h_q  <= 1'b1;
            fall_q   <= 1'b0;
        end else begin
            scl_s1_q <= scl_in;
            scl_s2_q <= scl_s1_q;
            scl_h_q  <= scl_s2_q;
            sda_s1_q <= sda_in;
            sda_s2_q <= sda_s1_q;
            sda_h_q  <= sda_s2_q;
            fall_q   <= scl_fall;
        end
    end

    // Protocol FSM, register file and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            bitcnt_q  <= 3'd0;
            shreg_q   <= 8'h00;
            ptr_q     <= '0;
            rw_q      <= 1'b0;
            ack_drv_q <= 1'b0;
            mack_q    <= 1'b0;
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= 8'h00;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else begin
            wr_en_q <= 1'b0;
            if (start_det) begin
                // START or repeated START: busy and pointer are kept
                state_q   <= S_ADDR;
                bitcnt_q  <= 3'd0;
                sda_oe_q  <= 1'b0;
                ack_drv_q <= 1'b0;
                mack_q    <= 1'b0;
            end else if (stop_det) begin
                // STOP: any partial byte is dropped
                state_q   <= S_IDLE;
                bitcnt_q  <= 3'd0;
                sda_oe_q  <= 1'b0;
                busy_q    <= 1'b0;
                ack_drv_q <= 1'b0;
                mack_q    <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE, S_WAIT_STOP: begin
                        // wait for START/STOP only
                    end
                    S_ADDR, S_PTR, S_WR_DATA: begin
                        if (scl_rise) begin
                            shreg_q  <= rx_byte_d;
                            bitcnt_q <= bitcnt_q + 3'd1;
                            if (bitcnt_q == 3'd7) begin
                                ack_drv_q <= 1'b0;
                                if (state_q == S_ADDR) begin
                                    if (addr_match) begin
                                        busy_q  <= 1'b1;
                                        rw_q    <= rx_byte_d[0];
                                        state_q <= S_ADDR_ACK;
                                    end else begin
                                        busy_q  <= 1'b0;
                                        state_q <= S_IDLE;
                                    end
                                end else if (state_q == S_PTR) begin
                                    ptr_q   <= rx_byte_d[PTR_W-1:0];
                                    state_q <= S_PTR_ACK;
                                end else begin
                                    regs_q[ptr_q] <= rx_byte_d;
                                    wr_en_q       <= 1'b1;
                                    wr_addr_q     <= ptr_q;
                                    wr_data_q     <= rx_byte_d;
                                    ptr_q         <= ptr_q + 1'b1;
                                    state_q       <= S_WR_ACK;
                                end
                            end
                        end
                    end
                    S_ADDR_ACK, S_PTR_ACK, S_WR_ACK: begin
                        // first falling edge starts the ACK, second one ends it
                        if (fall_q) begin
                            if (!ack_drv_q) begin
                                sda_oe_q  <= 1'b1;
                                ack_drv_q <= 1'b1;
                            end else begin
                                ack_drv_q <= 1'b0;
                                bitcnt_q  <= 3'd0;
                                if (state_q == S_ADDR_ACK && rw_q) begin
                                    shreg_q  <= rd_byte_d;
                                    sda_oe_q <= ~rd_byte_d[7];
                                    ptr_q    <= ptr_q + 1'b1;
                                    state_q  <= S_RD_DATA;
                                end else begin
                                    sda_oe_q <= 1'b0;
                                    state_q  <= (state_q == S_ADDR_ACK) ? S_PTR : S_WR_DATA;
                                end
                            end
                        end
                    end
                    S_RD_DATA: begin
                        // bit 7 went out on entry; each fall presents the next bit
                        if (fall_q) begin
                            if (bitcnt_q == 3'd7) begin
                                sda_oe_q <= 1'b0;
                                bitcnt_q <= 3'd0;
                                mack_q   <= 1'b0;
                                state_q  <= S_RD_ACK;
                            end else begin
                                sda_oe_q <= ~shreg_q[6];
                                shreg_q  <= {shreg_q[6:0], 1'b0};
                                bitcnt_q <= bitcnt_q + 3'd1;
                            end
                        end
                    end
                    S_RD_ACK: begin
                        if (scl_rise) begin
                            if (sda_s2_q) begin
                                state_q <= S_WAIT_STOP;
                            end else begin
                                mack_q <= 1'b1;
                            end
                        end else if (fall_q && mack_q) begin
                            mack_q   <= 1'b0;
                            bitcnt_q <= 3'd0;
                            shreg_q  <= rd_byte_d;
                            sda_oe_q <= ~rd_byte_d[7];
                            ptr_q    <= ptr_q + 1'b1;
                            state_q  <= S_RD_DATA;
                        end
                    end
                    default: begin
                        state_q  <= S_IDLE;
                        sda_oe_q <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: a bit-banged I2C master drives the bus, and a
// register/pointer model tracks what the target should hold and return.
module tb_i2c_target_regs;

    localparam int Q = 10; // clk cycles per quarter SCL period

    logic       clk = 1'b0;
    logic       reset;
    logic       scl_m, sda_m;
    logic       sda_oe, scl_oe;
    logic [3:0] loc_rd_addr;
    logic [7:0] loc_rd_data;
    logic       reg_wr_en;
    logic [3:0] reg_wr_addr;
    logic [7:0] reg_wr_data;
    logic       busy;
    logic [3:0] dbg_state;
    logic       sda_line;

    // open-drain wired-AND of master and target
    assign sda_line = sda_m & ~sda_oe;

    i2c_target_regs #(.DEV_ADDR(7'h42), .NUM_REGS(16), .PTR_W(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .scl_in      (scl_m),
        .sda_in      (sda_line),
        .sda_oe      (sda_oe),
        .scl_oe      (scl_oe),
        .loc_rd_addr (loc_rd_addr),
        .loc_rd_data (loc_rd_data),
        .reg_wr_en   (reg_wr_en),
        .reg_wr_addr (reg_wr_addr),
        .reg_wr_data (reg_wr_data),
        .busy        (busy),
        .dbg_state_o (dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // reference model
    logic [7:0]  model_regs [16];
    int          model_ptr;
    logic [11:0] exp_q [$];
    logic [11:0] got_q [$];
    logic [7:0]  wdata [8];

    // bus monitors
    logic quiet = 1'b0;
    int   quiet_viol = 0;
    int   oe_scl_high = 0;
    logic oe_prev = 1'b0;

    always @(negedge clk) begin
        if (!reset && reg_wr_en) got_q.push_back({reg_wr_addr, reg_wr_data});
        if (!reset && quiet && sda_oe) quiet_viol++;
        if (!reset && (sda_oe !== oe_prev) && scl_m) oe_scl_high++;
        oe_prev = sda_oe;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, observed hang expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wq();
        repeat (Q) @(negedge clk);
    endtask

    // master bus primitives
    task automatic m_start();
        sda_m = 1'b1; wq();
        scl_m = 1'b1; wq();
        sda_m = 1'b0; wq();
        scl_m = 1'b0; wq();
    endtask

    task automatic m_stop();
        sda_m = 1'b0; wq();
        scl_m = 1'b1; wq();
        sda_m = 1'b1; wq();
    endtask

    task automatic m_wbit(input logic b);
        sda_m = b;    wq();
        scl_m = 1'b1; wq(); wq();
        scl_m = 1'b0; wq();
    endtask

    task automatic m_rbit(output logic b);
        sda_m = 1'b1; wq();
        scl_m = 1'b1; wq();
        b = sda_line; wq();
        scl_m = 1'b0; wq();
    endtask

    task automatic m_wbyte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) m_wbit(d[i]);
        m_rbit(ack);
    endtask

    task automatic m_rbyte(output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            m_rbit(b);
            d[i] = b;
        end
    endtask

    // pointer + n data bytes from wdata, then STOP
    task automatic wr_txn(input logic [7:0] ptr, input int n);
        logic ack;
        m_start();
        m_wbyte(8'h84, ack); check("wr_addr_ack", ack, 0);
        check("busy_after_addr", busy, 1);
        m_wbyte(ptr, ack);   check("wr_ptr_ack", ack, 0);
        model_ptr = ptr % 16;
        for (int i = 0; i < n; i++) begin
            m_wbyte(wdata[i], ack); check("wr_data_ack", ack, 0);
            model_regs[model_ptr] = wdata[i];
            exp_q.push_back({4'(model_ptr), wdata[i]});
            model_ptr = (model_ptr + 1) % 16;
        end
        m_stop();
        check("busy_after_stop", busy, 0);
    endtask

    // optional pointer write, repeated START, read n bytes (ACK all but last)
    task automatic rd_txn(input bit set_ptr, input logic [7:0] ptr, input int n);
        logic ack;
        logic [7:0] d;
        m_start();
        if (set_ptr) begin
            m_wbyte(8'h84, ack); check("rd_waddr_ack", ack, 0);
            m_wbyte(ptr, ack);   check("rd_ptr_ack", ack, 0);
            model_ptr = ptr % 16;
            m_start();
        end
        m_wbyte(8'h85, ack); check("rd_addr_ack", ack, 0);
        check("busy_read", busy, 1);
        for (int i = 0; i < n; i++) begin
            m_rbyte(d);
            check("rd_data", d, model_regs[model_ptr]);
            model_ptr = (model_ptr + 1) % 16;
            m_wbit((i == n - 1) ? 1'b1 : 1'b0);
        end
        check("sda_released_after_nack", sda_oe, 0);
        m_stop();
        check("busy_after_rd_stop", busy, 0);
    endtask

    task automatic check_writes();
        check("wr_pulse_count", got_q.size(), exp_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            check("wr_pulse_addr_data", got_q.pop_front(), exp_q.pop_front());
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic check_all_regs();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            loc_rd_addr = 4'(i);
            #1;
            check("loc_rd_data", loc_rd_data, model_regs[i]);
        end
    endtask

    initial begin
        logic       ack;
        logic       b;
        int         n;
        logic [7:0] p;

        // reset
        reset = 1'b1;
        scl_m = 1'b1;
        sda_m = 1'b1;
        loc_rd_addr = 4'd0;
        for (int i = 0; i < 16; i++) model_regs[i] = 8'h00;
        model_ptr = 0;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset_sda_oe", sda_oe, 0);
        check("reset_scl_oe", scl_oe, 0);
        check("reset_wr_en", reg_wr_en, 0);
        check("reset_busy", busy, 0);
        check_all_regs();
        wq();

        // plain write: regs[3]=A5, regs[4]=5A
        wdata[0] = 8'hA5; wdata[1] = 8'h5A;
        wr_txn(8'h03, 2);
        check_writes();
        check_all_regs();

        // pointer 3, repeated START, read two bytes
        rd_txn(1'b1, 8'h03, 2);
        check("ptr_after_read", model_ptr, 5);
        // read continues from retained pointer 5
        rd_txn(1'b0, 8'h00, 1);

        // wrong address: nothing driven, nothing written
        quiet = 1'b1;
        m_start();
        m_wbyte(8'h44, ack); check("nomatch_addr_nack", ack, 1);
        check("nomatch_busy", busy, 0);
        for (int i = 0; i < 3; i++) begin
            m_wbyte(8'(8'h11 * (i + 3)), ack);
            check("nomatch_data_nack", ack, 1);
        end
        m_stop();
        quiet = 1'b0;
        check("nomatch_sda_quiet", quiet_viol, 0);
        check_writes();
        check_all_regs();

        // pointer wrap
        wdata[0] = 8'h11; wdata[1] = 8'h22;
        wr_txn(8'h0F, 2);
        check_writes();

        // STOP after 5 data bits: no write, pointer kept at 0
        m_start();
        m_wbyte(8'h84, ack); check("partial_addr_ack", ack, 0);
        m_wbyte(8'h00, ack); check("partial_ptr_ack", ack, 0);
        model_ptr = 0;
        m_wbit(1'b1); m_wbit(1'b0); m_wbit(1'b1); m_wbit(1'b1); m_wbit(1'b0);
        m_stop();
        check_writes();
        rd_txn(1'b0, 8'h00, 1);
        check_all_regs();

        // randomized write/read traffic
        for (int t = 0; t < 4; t++) begin
            n = $urandom_range(1, 3);
            p = 8'($urandom);
            for (int i = 0; i < n; i++) wdata[i] = 8'($urandom);
            wr_txn(p, n);
            check_writes();
            rd_txn(1'b1, 8'($urandom), $urandom_range(1, 3));
            rd_txn(1'b0, 8'h00, 1);
        end
        check_all_regs();

        // reset in the middle of a read while bit 3 pulls SDA low
        wdata[0] = 8'hF0;
        wr_txn(8'h07, 1);
        check_writes();
        m_start();
        m_wbyte(8'h84, ack); check("rst_waddr_ack", ack, 0);
        m_wbyte(8'h07, ack); check("rst_ptr_ack", ack, 0);
        m_start();
        m_wbyte(8'h85, ack); check("rst_raddr_ack", ack, 0);
        for (int i = 0; i < 4; i++) begin
            m_rbit(b);
            check("rst_read_hi_bits", b, 1);
        end
        check("rst_bit3_driven", sda_oe, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("rst_sda_released", sda_oe, 0);
        check("rst_busy_clear", busy, 0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) model_regs[i] = 8'h00;
        model_ptr = 0;
        exp_q.delete();
        got_q.delete();
        m_stop();
        wdata[0] = 8'h3C;
        wr_txn(8'h02, 1);
        check_writes();
        check_all_regs();

        check("sda_oe_moved_with_scl_high", oe_scl_high, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
